// File: rtl/a429_tx.sv
// a429_tx: ARINC429 bipolar return-to-zero transmitter fed by a first-word-fall-through FIFO.
// Define A429_TX_PARERR_EN to add the par_err_i input that forces even parity for one word.
module a429_tx #(
  parameter int CLOCK_KHZ = 100000,
  parameter int GAP_BITS  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        tf_rd,
  input  logic [31:0] tf_do,
  input  logic        tf_em,
  input  logic        tx_ena,
  input  logic        hi_spd,
`ifdef A429_TX_PARERR_EN
  input  logic        par_err_i,
`endif
  output logic [1:0]  tx_ab_o,
  output logic        busy_o,
  output logic        tx_done_o
);

  function automatic int calc_cw(input int value);
    int width;
    width = 1;
    for (int i = 0; i < 31; i++) begin
      if (value >= (1 << i)) width = i + 1;
    end
    return width;
  endfunction

  localparam int BIT_HI  = CLOCK_KHZ / 100;
  localparam int BIT_LO  = CLOCK_KHZ * 8 / 100;
  localparam int HALF_HI = BIT_HI / 2;
  localparam int HALF_LO = BIT_LO / 2;
  localparam int GAP_HI  = GAP_BITS * BIT_HI;
  localparam int GAP_LO  = GAP_BITS * BIT_LO;
  localparam int CW      = calc_cw(8 * CLOCK_KHZ * GAP_BITS / 100);

  localparam logic [CW-1:0] HALF_HI_TC = CW'(HALF_HI - 1);
  localparam logic [CW-1:0] HALF_LO_TC = CW'(HALF_LO - 1);
  localparam logic [CW-1:0] GAP_HI_TC  = CW'(GAP_HI - 1);
  localparam logic [CW-1:0] GAP_LO_TC  = CW'(GAP_LO - 1);

  typedef enum logic [1:0] {IDLE, HI, NUL, GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    bit_reg, bit_next;
  logic [31:0]   shift_reg, shift_next;
  logic          spd_reg, spd_next;
  logic          rd_reg, rd_next;
  logic [1:0]    ab_reg, ab_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          load;
  logic [CW-1:0] half_tc;
  logic [CW-1:0] gap_tc;

  // Line order of the FIFO word: label reversed, then data, then SDI, then parity.
  logic [30:0] ser_data;
  logic        ser_parity;
  logic        par_inv;
  logic        unused_bit8;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_label
      assign ser_data[gi] = tf_do[7-gi];
    end
    for (gi = 8; gi < 29; gi++) begin : g_data
      assign ser_data[gi] = tf_do[gi+3];
    end
  endgenerate

  assign ser_data[29] = tf_do[9];
  assign ser_data[30] = tf_do[10];
  // Bit 8 never reaches the line; its slot is taken by the generated parity.
  assign unused_bit8  = tf_do[8];

`ifdef A429_TX_PARERR_EN
  assign par_inv = par_err_i;
`else
  assign par_inv = 1'b0;
`endif

  assign ser_parity = ~(^ser_data) ^ par_inv;

  assign half_tc = spd_reg ? HALF_HI_TC : HALF_LO_TC;
  assign gap_tc  = spd_reg ? GAP_HI_TC : GAP_LO_TC;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= GAP;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      spd_reg   <= 1'b1;
      rd_reg    <= 1'b0;
      ab_reg    <= 2'b00;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      spd_reg   <= spd_next;
      rd_reg    <= rd_next;
      ab_reg    <= ab_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // The line register follows the state by one cycle, so bit 0 appears right after tf_rd.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    spd_next   = spd_reg;
    busy_next  = busy_reg;
    rd_next    = 1'b0;
    done_next  = 1'b0;
    ab_next    = 2'b00;
    load       = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        load      = tx_ena && !tf_em;
      end
      HI: begin
        ab_next = shift_reg[0] ? 2'b10 : 2'b01;
        if (cnt_reg == half_tc) begin
          state_next = NUL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      NUL: begin
        if (cnt_reg == half_tc) begin
          cnt_next = '0;
          if (bit_reg == 5'd31) begin
            state_next = GAP;
            done_next  = 1'b1;
          end else begin
            state_next = HI;
            bit_next   = bit_reg + 5'd1;
            shift_next = {1'b0, shift_reg[31:1]};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the first idle decision so words stay back-to-back.
        if (cnt_reg == gap_tc) begin
          cnt_next = '0;
          if (tx_ena && !tf_em) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = GAP;
        cnt_next   = '0;
      end
    endcase

    if (load) begin
      state_next = HI;
      cnt_next   = '0;
      bit_next   = '0;
      shift_next = {ser_parity, ser_data};
      spd_next   = hi_spd;
      rd_next    = 1'b1;
      busy_next  = 1'b1;
    end
  end

  assign tf_rd     = rd_reg;
  assign tx_ab_o   = ab_reg;
  assign busy_o    = busy_reg;
  assign tx_done_o = done_reg;

endmodule

// File: tb/tb_a429_tx.sv
// tb_a429_tx: randomized bench for a429_tx with a cycle-level reference model of the line protocol.
`timescale 1ns/1ps
module tb_a429_tx;

  localparam int CLOCK_KHZ = 1000;
  localparam int GAP_BITS  = 4;
  localparam int BIT_HI    = CLOCK_KHZ / 100;
  localparam int BIT_LO    = CLOCK_KHZ * 8 / 100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        tf_rd;
  logic [31:0] tf_do;
  logic        tf_em;
  logic        tx_ena = 1'b1;
  logic        hi_spd = 1'b1;
  logic [1:0]  tx_ab_o;
  logic        busy_o;
  logic        tx_done_o;
`ifdef A429_TX_PARERR_EN
  logic        par_err_i = 1'b0;
`endif

  logic [31:0] words [0:63];
  int          wr_idx = 0;
  int          rd_idx = 0;

  assign tf_em = (wr_idx == rd_idx);
  assign tf_do = words[rd_idx[5:0]];

  a429_tx #(.CLOCK_KHZ(CLOCK_KHZ), .GAP_BITS(GAP_BITS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tf_rd     (tf_rd),
    .tf_do     (tf_do),
    .tf_em     (tf_em),
    .tx_ena    (tx_ena),
    .hi_spd    (hi_spd),
`ifdef A429_TX_PARERR_EN
    .par_err_i (par_err_i),
`endif
    .tx_ab_o   (tx_ab_o),
    .busy_o    (busy_o),
    .tx_done_o (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line image of a word: bit index on the line -> word bit, parity makes the ones odd.
  function automatic logic [31:0] model_serial(input logic [31:0] w, input logic perr);
    logic [31:0] s;
    int          src;
    s = '0;
    for (int i = 0; i < 31; i++) begin
      if (i < 8)        src = 7 - i;
      else if (i <= 28) src = i + 3;
      else if (i == 29) src = 9;
      else              src = 10;
      s[i] = w[src];
    end
    s[31] = (($countones(s[30:0]) % 2) == 0) ^ perr;
    return s;
  endfunction

  // Inputs as the DUT saw them at the edge that opened the current cycle.
  logic        rst_s = 1'b0, ena_s = 1'b0, em_s = 1'b1, spd_s = 1'b1, perr_s = 1'b0;
  logic [31:0] head_s = '0;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      rst_s  = rst_i;
      ena_s  = tx_ena;
      em_s   = tf_em;
      spd_s  = hi_spd;
      head_s = tf_do;
`ifdef A429_TX_PARERR_EN
      perr_s = par_err_i;
`endif
    end
  end

  // Reference model state
  bit          started = 0;
  bit          wv = 0;
  int          t0 = 0;
  int          bclk = BIT_HI;
  int          earliest = 0;
  logic [31:0] sv = '0;
  int          last_rd = 0, prev_rd = 0, last_done = 0, n_rd = 0, n_done = 0;

  task automatic monitor_step();
    bit         exp_rd, exp_done, exp_busy;
    logic [1:0] exp_line;
    int         r;
    if (!rst_s) begin
      started  = 1;
      wv       = 0;
      earliest = cyc + GAP_BITS * BIT_HI;
      check_eq("rst_line", tx_ab_o, 2'b00);
      check_eq("rst_rd", tf_rd, 1'b0);
      check_eq("rst_done", tx_done_o, 1'b0);
      check_eq("rst_busy", busy_o, 1'b1);
    end else if (started) begin
      exp_rd = (cyc >= earliest) && ena_s && !em_s;
      if (exp_rd) begin
        wv       = 1;
        t0       = cyc;
        bclk     = spd_s ? BIT_HI : BIT_LO;
        sv       = model_serial(head_s, perr_s);
        earliest = cyc + (32 + GAP_BITS) * bclk;
      end
      exp_line = 2'b00;
      if (wv && cyc > t0 && cyc <= t0 + 32 * bclk) begin
        r = cyc - t0 - 1;
        if ((r % bclk) < bclk / 2) exp_line = sv[r / bclk] ? 2'b10 : 2'b01;
      end
      exp_done = wv && (cyc == t0 + 32 * bclk);
      exp_busy = !((cyc >= earliest) && !exp_rd);
      check_eq("line", tx_ab_o, exp_line);
      check_eq("rd", tf_rd, exp_rd);
      check_eq("done", tx_done_o, exp_done);
      check_eq("busy", busy_o, exp_busy);
      if (exp_done) $display("word line=%h bclk=%0d done at cycle %0d", sv, bclk, cyc);
    end
    if (tf_rd === 1'b1) begin
      rd_idx++;
      prev_rd = last_rd;
      last_rd = cyc;
      n_rd++;
    end
    if (tx_done_o === 1'b1) begin
      last_done = cyc;
      n_done++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      monitor_step();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    words[wr_idx[5:0]] = w;
    wr_idx++;
  endtask

  int  edges, rd0, done0;
  bit  fell, seen;

  initial begin
    for (int i = 0; i < 64; i++) words[i] = '0;
    step(5);

    // Reset release with an empty FIFO: busy drops on the 40th edge.
    rst_i = 1'b1;
    edges = 0;
    fell  = 0;
    for (int i = 0; i < 200 && !fell; i++) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (!busy_o) fell = 1;
    end
    check_eq("busy_fall_edges", edges, 40);
    step(20);

    // Single label word at high speed.
    rd0 = n_rd;
    push_word(32'h0000_00C5);
    step(400);
    check_eq("c5_rd_pulses", n_rd - rd0, 1);
    check_eq("c5_done_latency", last_done - last_rd, 320);

    // Two queued words run back-to-back.
    push_word($urandom);
    push_word($urandom);
    step(800);
    check_eq("b2b_interval", last_rd - prev_rd, 360);

    // Low speed all-ones word, speed input toggled while it is on the line.
    hi_spd = 1'b0;
    push_word(32'hFFFF_FFFF);
    step(300);
    hi_spd = 1'b1;
    step(600);
    hi_spd = 1'b0;
    step(2100);
    check_eq("lo_done_latency", last_done - last_rd, 32 * BIT_LO);
    hi_spd = 1'b1;
    step(20);

    // Reset in the middle of bit 12; the following word must still go out intact.
    done0 = n_done;
    push_word($urandom);
    push_word($urandom);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      if (tf_rd) seen = 1;
    end
    check_eq("rst_test_rd_seen", seen, 1'b1);
    step(122);
    rst_i = 1'b0;
    step(1);
    rst_i = 1'b1;
    step(500);
    check_eq("rst_test_done_cnt", n_done - done0, 1);

`ifdef A429_TX_PARERR_EN
    par_err_i = 1'b1;
    push_word(32'h0000_00C5);
    step(3);
    par_err_i = 1'b0;
    step(400);
`endif

    // Random words with tx_ena pauses.
    for (int i = 0; i < 4; i++) push_word($urandom);
    for (int i = 0; i < 8; i++) begin
      tx_ena = ($urandom_range(0, 3) != 0);
`ifdef A429_TX_PARERR_EN
      par_err_i = $urandom_range(0, 1);
`endif
      step($urandom_range(50, 300));
    end
    tx_ena = 1'b1;
    step(4 * 360 + 100);
    check_eq("all_popped", rd_idx, wr_idx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
